// File: rtl/vetores_pkg.sv
// Shared definitions for the serial vector loader: default width, FSM encoding, counter width.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package vetores_pkg;

    // Default width of each of the a and b vectors.
    localparam int LARGURA_PADRAO = 3;

    // Loader FSM encoding.
    localparam logic COLETA = 1'b0;
    localparam logic PRONTO = 1'b1;

    // Width of the bit counter for a frame of 2*largura bits, never below 1.
    function automatic int cw_de(input int largura);
        int w;
        w = $clog2(2 * largura);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/carregador_vetores.sv
// Serial-to-parallel loader: assembles a 2*LARGURA-bit frame {b, a}, LSB first, from a valid-qualified bit stream.
// Latency: a/b and vetores_valido appear 1 cycle after the last bit of the frame is accepted.
// Backpressure: while a frame waits for vetores_pronto, incoming bits are dropped and erro_overflow is set (sticky).
module carregador_vetores
    import vetores_pkg::*;
#(
    parameter int LARGURA = LARGURA_PADRAO,
    localparam int CW = cw_de(LARGURA)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               bit_in,
    input  logic               bit_valido,
    input  logic               limpar,
    input  logic               vetores_pronto,
    output logic [LARGURA-1:0] a,
    output logic [LARGURA-1:0] b,
    output logic               vetores_valido,
    output logic               ocupado,
    output logic [CW-1:0]      contagem_bits,
    output logic               erro_overflow
);

    localparam int NBITS = 2 * LARGURA;
    localparam logic [CW-1:0] ULTIMO = CW'(NBITS - 1);

    logic             estado;
    logic [NBITS-1:0] palavra;
    logic [NBITS-1:0] palavra_nova;

    // Frame word with the offered bit written at the current position.
    always_comb begin
        palavra_nova = palavra;
        palavra_nova[contagem_bits] = bit_in;
    end

    // FSM, bit counter, shift word and output registers; limpar behaves like a reset.
    always_ff @(posedge clk) begin
        if (rst || limpar) begin
            estado        <= COLETA;
            palavra       <= '0;
            contagem_bits <= '0;
            a             <= '0;
            b             <= '0;
            erro_overflow <= 1'b0;
        end else begin
            case (estado)
                COLETA: begin
                    if (bit_valido) begin
                        if (contagem_bits == ULTIMO) begin
                            a             <= palavra_nova[LARGURA-1:0];
                            b             <= palavra_nova[NBITS-1:LARGURA];
                            palavra       <= '0;
                            contagem_bits <= '0;
                            estado        <= PRONTO;
                        end else begin
                            palavra       <= palavra_nova;
                            contagem_bits <= contagem_bits + CW'(1);
                        end
                    end
                end
                default: begin
                    if (vetores_pronto) begin
                        // Transfer; a bit offered in the same cycle starts the next frame
                        // (counter is 0 and the word was cleared at completion).
                        estado <= COLETA;
                        if (bit_valido) begin
                            palavra       <= palavra_nova;
                            contagem_bits <= contagem_bits + CW'(1);
                        end
                    end else if (bit_valido) begin
                        erro_overflow <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign vetores_valido = (estado == PRONTO);
    assign ocupado        = (estado == COLETA) && (contagem_bits != '0);

endmodule

// File: tb/tb_carregador_vetores.sv
// Self-checking bench for carregador_vetores: directed scenarios plus random traffic against a queue-based model.
// Latency: checks status outputs 1 ns after each rising edge; frame transfers scoreboarded at falling edges.
// Backpressure: consumer ready is driven directly and also randomised.
module tb_carregador_vetores;

    localparam int L  = 3;
    localparam int CW = vetores_pkg::cw_de(L);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          bit_in = 1'b0;
    logic          bit_valido = 1'b0;
    logic          limpar = 1'b0;
    logic          vetores_pronto = 1'b0;
    logic [L-1:0]  a;
    logic [L-1:0]  b;
    logic          vetores_valido;
    logic          ocupado;
    logic [CW-1:0] contagem_bits;
    logic          erro_overflow;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state
    bit             frame_q[$];
    bit             m_pend;
    bit             m_err;
    logic [L-1:0]   m_a;
    logic [L-1:0]   m_b;
    logic [2*L-1:0] sb_q[$];

    carregador_vetores #(.LARGURA(L)) dut (
        .clk(clk),
        .rst(rst),
        .bit_in(bit_in),
        .bit_valido(bit_valido),
        .limpar(limpar),
        .vetores_pronto(vetores_pronto),
        .a(a),
        .b(b),
        .vetores_valido(vetores_valido),
        .ocupado(ocupado),
        .contagem_bits(contagem_bits),
        .erro_overflow(erro_overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
        n_chk++;
        if (atual !== esperado) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nome, atual, esperado, $time);
        end
    endtask

    // Model update for one clock edge with the inputs that were applied.
    task automatic modelo(input bit r, input bit l, input bit bv, input bit bi, input bit pr);
        if (r || l) begin
            frame_q.delete();
            sb_q.delete();
            m_pend = 0;
            m_err  = 0;
            m_a    = '0;
            m_b    = '0;
        end else if (m_pend) begin
            if (pr) begin
                m_pend = 0;
                if (bv) frame_q.push_back(bi);
            end else if (bv) begin
                m_err = 1;
            end
        end else if (bv) begin
            frame_q.push_back(bi);
            if (frame_q.size() == 2 * L) begin
                for (int i = 0; i < L; i++) begin
                    m_a[i] = frame_q[i];
                    m_b[i] = frame_q[L + i];
                end
                m_pend = 1;
                sb_q.push_back({m_b, m_a});
                frame_q.delete();
            end
        end
    endtask

    task automatic checa_saidas();
        chk("a", 32'(a), 32'(m_a));
        chk("b", 32'(b), 32'(m_b));
        chk("vetores_valido", 32'(vetores_valido), 32'(m_pend));
        chk("ocupado", 32'(ocupado), 32'(!m_pend && frame_q.size() != 0));
        chk("contagem_bits", 32'(contagem_bits), 32'(frame_q.size()));
        chk("erro_overflow", 32'(erro_overflow), 32'(m_err));
    endtask

    // One clock cycle: apply inputs, advance model at the edge, check outputs just after it.
    task automatic ciclo(input bit r, input bit l, input bit bv, input bit bi, input bit pr);
        rst = r; limpar = l; bit_valido = bv; bit_in = bi; vetores_pronto = pr;
        @(posedge clk);
        modelo(r, l, bv, bi, pr);
        #1;
        checa_saidas();
        #1;
    endtask

    // Send n bits of 'bits' LSB first, with 'gap' idle cycles after each bit.
    task automatic enviar(input logic [7:0] bits, input int n, input int gap, input bit pr);
        for (int i = 0; i < n; i++) begin
            ciclo(0, 0, 1, bits[i], pr);
            for (int g = 0; g < gap; g++) ciclo(0, 0, 0, 0, pr);
        end
    endtask

    // Scoreboard monitor: a transfer happens when valid and ready are both high.
    initial begin
        logic [2*L-1:0] esp;
        forever begin
            @(negedge clk);
            if (vetores_valido === 1'b1 && vetores_pronto === 1'b1) begin
                if (sb_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL sb_unexpected: got {b,a}=%0h expected no transfer at %0t", {b, a}, $time);
                end else begin
                    esp = sb_q.pop_front();
                    chk("sb_ab", 32'({b, a}), 32'(esp));
                end
            end
        end
    end

    initial begin
        m_pend = 0; m_err = 0; m_a = '0; m_b = '0;
        #2;
        // Reset
        ciclo(1, 0, 0, 0, 0);
        ciclo(1, 0, 1, 1, 1);
        ciclo(0, 0, 0, 0, 0);

        // Back-to-back frame 1,1,0,1,0,1 with ready held high
        enviar(8'b101011, 6, 0, 1);
        chk("dir1_a", 32'(a), 32'(3'b011));
        chk("dir1_b", 32'(b), 32'(3'b101));
        chk("dir1_or", 32'(a | b), 32'(3'b111));
        ciclo(0, 0, 0, 0, 1);

        // Same frame with two idle cycles between bits
        enviar(8'b101011, 6, 2, 1);
        chk("dir2_a", 32'(a), 32'(3'b011));
        ciclo(0, 0, 0, 0, 1);

        // Overflow: frame completes with ready low, then an extra bit
        enviar(8'b000111, 6, 0, 0);
        ciclo(0, 0, 1, 0, 0);
        chk("dir3_err", 32'(erro_overflow), 32'(1));
        ciclo(0, 0, 0, 0, 0);
        ciclo(0, 0, 0, 0, 1);
        chk("dir3_valido_low", 32'(vetores_valido), 32'(0));

        // Transfer and new bit on the same cycle
        enviar(8'b010101, 6, 0, 0);
        ciclo(0, 0, 1, 1, 1);
        chk("dir4_contagem", 32'(contagem_bits), 32'(1));
        enviar(8'b00110, 5, 0, 1);
        chk("dir4_a0", 32'(a[0]), 32'(1));
        ciclo(0, 0, 0, 0, 1);

        // limpar mid-frame with a bit offered, then fresh frame 0,0,1,1,1,0
        ciclo(1, 0, 0, 0, 1);
        enviar(8'b1011, 4, 0, 1);
        ciclo(0, 1, 1, 1, 1);
        chk("dir5_contagem", 32'(contagem_bits), 32'(0));
        enviar(8'b011100, 6, 0, 1);
        chk("dir5_a", 32'(a), 32'(3'b100));
        chk("dir5_b", 32'(b), 32'(3'b011));
        ciclo(0, 0, 0, 0, 1);

        // Reset mid-frame, then a full frame with no residue
        enviar(8'b111, 3, 0, 1);
        ciclo(1, 0, 0, 0, 1);
        chk("dir6_ocupado", 32'(ocupado), 32'(0));
        enviar(8'b000000, 6, 0, 1);
        chk("dir6_a", 32'(a), 32'(0));
        ciclo(0, 0, 0, 0, 1);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            ciclo(($urandom_range(0, 199) == 0),
                  ($urandom_range(0, 99) == 0),
                  ($urandom_range(0, 1) == 1),
                  ($urandom_range(0, 1) == 1),
                  ($urandom_range(0, 2) == 0));
        end

        // Drain any pending frame
        for (int i = 0; i < 3; i++) ciclo(0, 0, 0, 0, 1);
        chk("sb_drained", 32'(sb_q.size()), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
